// File: rtl/sseg_pkg.sv
// Shared types and constants for the 7-segment display arbiter.
package sseg_pkg;

    typedef enum logic {
        StIdle,
        StDwell
    } state_e;

    localparam int unsigned DISP_W          = 16;
    localparam int unsigned HOLD_CYCLES_DEF = 100_000_000;

    // Minimum result of 1 so a 1-requester build still gets a legal vector width.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request after last_owner, wrapping.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned OWN_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [OWN_W-1:0] last_owner,
    output logic             any,
    output logic [OWN_W-1:0] winner
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    int unsigned        start;
    int unsigned        offs;
    int unsigned        idx;

    always_comb begin
        start = 32'(last_owner) + 32'd1;
        if (start >= N_REQ) start = 0;
        // Doubling the vector turns the rotate into a plain right shift.
        dbl = {req, req};
        rot = N_REQ'(dbl >> start);
        offs = 0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (rot[i]) offs = 32'(i);
        end
        idx = start + offs;
        if (idx >= N_REQ) idx = idx - N_REQ;
        any    = |req;
        winner = OWN_W'(idx);
    end

endmodule

// File: rtl/sseg_display_arbiter.sv
// Round-robin sharing of one 4-digit 7-segment display; each grant dwells HOLD_CYCLES,
// otherwise the display follows idle_value.
module sseg_display_arbiter
    import sseg_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int unsigned CNT_W       = 27,
    parameter int unsigned OWN_W       = clog2(N_REQ)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [DISP_W*N_REQ-1:0]   req_value,
    input  logic                      freeze,
    input  logic [DISP_W-1:0]         idle_value,
    output logic [N_REQ-1:0]          ack,
    output logic [DISP_W-1:0]         disp_value,
    output logic [OWN_W-1:0]          disp_owner,
    output logic                      disp_busy
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OWN_W-1:0]   last_q, last_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [DISP_W-1:0]  value_q, value_d;
    logic [OWN_W-1:0]   owner_q, owner_d;
    logic               busy_q, busy_d;

    logic               any;
    logic [OWN_W-1:0]   winner;
    logic [DISP_W-1:0]  sel_value;
    logic               grant;

    rr_pick #(
        .N_REQ (N_REQ),
        .OWN_W (OWN_W)
    ) u_rr_pick (
        .req        (req),
        .last_owner (last_q),
        .any        (any),
        .winner     (winner)
    );

    always_comb begin
        sel_value = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (winner == OWN_W'(i)) sel_value = req_value[DISP_W*i +: DISP_W];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        ack_d   = '0;
        value_d = value_q;
        owner_d = owner_q;
        busy_d  = busy_q;
        grant   = 1'b0;

        if (!freeze) begin
            unique case (state_q)
                StIdle: begin
                    if (any) grant = 1'b1;
                    else     value_d = idle_value;
                end
                StDwell: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (any) begin
                        grant = 1'b1;
                    end else begin
                        busy_d  = 1'b0;
                        value_d = idle_value;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (grant) begin
            value_d        = sel_value;
            ack_d[winner]  = 1'b1;
            owner_d        = winner;
            busy_d         = 1'b1;
            last_d         = winner;
            cnt_d          = CNT_W'(HOLD_CYCLES - 1);
            state_d        = StDwell;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            last_q  <= OWN_W'(N_REQ - 1);
            ack_q   <= '0;
            value_q <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
            value_q <= value_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
        end
    end

    assign ack        = ack_q;
    assign disp_value = value_q;
    assign disp_owner = owner_q;
    assign disp_busy  = busy_q;

endmodule

// File: tb/tb_sseg_display_arbiter.sv
// Directed bench for sseg_display_arbiter with a grant scoreboard checked on every ack.
module tb_sseg_display_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] req_value;
    logic        freeze;
    logic [15:0] idle_value;
    logic [3:0]  ack;
    logic [15:0] disp_value;
    logic [1:0]  disp_owner;
    logic        disp_busy;

    typedef struct packed {
        logic [1:0]  owner;
        logic [15:0] value;
    } grant_t;

    grant_t exp_q[$];
    int     total   = 0;
    int     bad     = 0;
    int     ack_cnt = 0;

    sseg_display_arbiter #(
        .N_REQ       (4),
        .HOLD_CYCLES (4),
        .CNT_W       (3),
        .OWN_W       (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .req_value  (req_value),
        .freeze     (freeze),
        .idle_value (idle_value),
        .ack        (ack),
        .disp_value (disp_value),
        .disp_owner (disp_owner),
        .disp_busy  (disp_busy)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_val(input int i, input logic [15:0] v);
        req_value[16*i +: 16] = v;
    endtask

    task automatic push(input int owner, input logic [15:0] v);
        grant_t g;
        g.owner = 2'(owner);
        g.value = v;
        exp_q.push_back(g);
    endtask

    // One clock; sample 1 ns after the edge, score any ack, and let the requester drop req.
    task automatic step();
        grant_t e;
        int     idx;
        @(posedge clock);
        #1;
        if (ack != 4'b0) begin
            ack_cnt++;
            check("ack_onehot", 32'($countones(ack)), 32'd1);
            idx = 0;
            for (int i = 0; i < 4; i++) if (ack[i]) idx = i;
            if (exp_q.size() == 0) begin
                check("ack_unexpected", 32'(ack), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("grant_ack_idx", 32'(idx), 32'(e.owner));
                check("grant_owner", 32'(disp_owner), 32'(e.owner));
                check("grant_value", 32'(disp_value), 32'(e.value));
                check("grant_busy", 32'(disp_busy), 32'd1);
            end
            req = req & ~ack;
        end
    endtask

    task automatic wait_ack(input string tag);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (ack != 4'b0) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_timeout"}, 32'(got), 32'd1);
    endtask

    task automatic check_disp(input string tag, input logic [15:0] v, input logic busy);
        check({tag, "_value"}, 32'(disp_value), 32'(v));
        check({tag, "_busy"}, 32'(disp_busy), 32'(busy));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int base;
        int shown;

        reset      = 1'b1;
        req        = 4'b0;
        req_value  = 64'b0;
        freeze     = 1'b0;
        idle_value = 16'h1234;

        // Reset and idle tracking
        step();
        step();
        reset = 1'b0;
        check_disp("rst", 16'h0000, 1'b0);
        check("rst_owner", 32'(disp_owner), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        step();
        check_disp("idle_1234", 16'h1234, 1'b0);
        idle_value = 16'h5678;
        step();
        check_disp("idle_5678", 16'h5678, 1'b0);
        idle_value = 16'h1234;
        step();

        // Single grant on requester 2
        set_val(2, 16'hBEEF);
        req[2] = 1'b1;
        push(2, 16'hBEEF);
        step();
        check("single_ack", 32'(ack), 32'h4);
        for (int c = 2; c <= 4; c++) begin
            step();
            check_disp("single_dwell", 16'hBEEF, 1'b1);
            check("single_dwell_owner", 32'(disp_owner), 32'd2);
            check("single_dwell_ack", 32'(ack), 32'd0);
        end
        step();
        check_disp("single_end", 16'h1234, 1'b0);

        // Simultaneous requests 0 and 3 after reset, back-to-back with no idle gap
        do_reset();
        base = ack_cnt;
        set_val(0, 16'hAAAA);
        set_val(3, 16'hDDDD);
        req = 4'b1001;
        push(0, 16'hAAAA);
        push(3, 16'hDDDD);
        for (int c = 1; c <= 8; c++) begin
            step();
            check_disp("simul", (c <= 4) ? 16'hAAAA : 16'hDDDD, 1'b1);
            check("simul_owner", 32'(disp_owner), (c <= 4) ? 32'd0 : 32'd3);
        end
        step();
        check_disp("simul_end", 16'h1234, 1'b0);
        check("simul_ack_count", 32'(ack_cnt - base), 32'd2);

        // Fairness with all four requesters continuously re-requesting
        for (int i = 0; i < 4; i++) set_val(i, 16'h1111 * 16'(i + 1));
        req = 4'hF;
        push(0, 16'h1111);
        push(1, 16'h2222);
        push(2, 16'h3333);
        push(3, 16'h4444);
        push(0, 16'h1111);
        push(1, 16'h2222);
        for (int g = 0; g < 6; g++) begin
            wait_ack("fair");
            req = (g < 5) ? 4'hF : 4'h0;
        end
        for (int c = 0; c < 5; c++) step();
        check_disp("fair_end", 16'h1234, 1'b0);
        check("fair_queue_empty", 32'(exp_q.size()), 32'd0);

        // Freeze mid-dwell stretches the grant to 14 cycles
        set_val(1, 16'h5555);
        req = 4'b0010;
        push(1, 16'h5555);
        wait_ack("frz");
        shown  = 1;
        freeze = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            check_disp("frz_hold", 16'h5555, 1'b1);
            check("frz_ack", 32'(ack), 32'd0);
            shown++;
        end
        freeze = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (disp_value === 16'h5555 && disp_busy === 1'b1) shown++;
            else break;
        end
        check("frz_shown_cycles", 32'(shown), 32'd14);
        check_disp("frz_end", 16'h1234, 1'b0);

        // Freeze in idle stops idle tracking
        freeze     = 1'b1;
        idle_value = 16'h9999;
        for (int c = 0; c < 3; c++) begin
            step();
            check_disp("frz_idle", 16'h1234, 1'b0);
        end
        freeze = 1'b0;
        step();
        check_disp("frz_idle_release", 16'h9999, 1'b0);
        idle_value = 16'h1234;
        step();

        // Asynchronous reset mid-dwell, then re-arbitration from requester 0
        set_val(2, 16'h7777);
        req = 4'b0100;
        push(2, 16'h7777);
        wait_ack("arst_pre");
        step();
        #2;
        reset = 1'b1;
        #1;
        check_disp("arst_async", 16'h0000, 1'b0);
        check("arst_owner", 32'(disp_owner), 32'd0);
        check("arst_ack", 32'(ack), 32'd0);
        check("arst_queue_empty", 32'(exp_q.size()), 32'd0);
        set_val(1, 16'h1010);
        set_val(3, 16'h3030);
        req = 4'b1010;
        push(1, 16'h1010);
        push(3, 16'h3030);
        step();
        check_disp("arst_held", 16'h0000, 1'b0);
        reset = 1'b0;
        wait_ack("arst_first");
        wait_ack("arst_second");
        for (int c = 0; c < 5; c++) step();
        check_disp("arst_end", 16'h1234, 1'b0);
        check("arst_final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
